// File: rtl/buffer_fifo_pkg.sv
// Shared constants for the FIFO controller that drives an external 64x24 storage array.
package buffer_fifo_pkg;

  localparam int DW        = 24;
  localparam int AW        = 6;
  localparam int DEPTH     = 1 << AW;
  localparam int AFULL_TH  = 56;
  localparam int AEMPTY_TH = 8;

endpackage : buffer_fifo_pkg

// File: rtl/fifo_ptr_cnt.sv
// Write/read pointers and occupancy counter, advanced only on accepted accesses.
module fifo_ptr_cnt #(
  parameter int AW = buffer_fifo_pkg::AW
) (
  input  logic          memclk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push_acc,
  input  logic          pop_acc,
  output logic [AW-1:0] wr_ptr,
  output logic [AW-1:0] rd_ptr,
  output logic [AW:0]   count
);

  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;

  // Pointers are one bit narrower than count, so they wrap 63 -> 0 naturally.
  always_ff @(posedge memclk) begin
    if (rst || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_acc) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_acc)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (push_acc && !pop_acc)      count_reg <= count_reg + 1'b1;
      else if (pop_acc && !push_acc) count_reg <= count_reg - 1'b1;
    end
  end

  assign wr_ptr = wr_ptr_reg;
  assign rd_ptr = rd_ptr_reg;
  assign count  = count_reg;

endmodule : fifo_ptr_cnt

// File: rtl/buffer_fifo_ctrl.sv
// FIFO controller: accept/reject logic, storage drive, status flags and sticky errors.
module buffer_fifo_ctrl #(
  parameter int DW        = buffer_fifo_pkg::DW,
  parameter int AW        = buffer_fifo_pkg::AW,
  parameter int AFULL_TH  = buffer_fifo_pkg::AFULL_TH,
  parameter int AEMPTY_TH = buffer_fifo_pkg::AEMPTY_TH
) (
  input  logic          memclk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  input  logic          flush,
  input  logic          clr_err,
  output logic          mem_wren,
  output logic [AW-1:0] mem_wrptr,
  output logic [DW-1:0] mem_wrdata,
  output logic          mem_rden,
  output logic [AW-1:0] mem_rdptr,
  output logic          rd_valid,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic [AW:0]   count,
  output logic          ovf_err,
  output logic          udf_err
);

  localparam logic [AW:0] FULL_CNT   = (AW+1)'(1 << AW);
  localparam logic [AW:0] AFULL_CNT  = (AW+1)'(AFULL_TH);
  localparam logic [AW:0] AEMPTY_CNT = (AW+1)'(AEMPTY_TH);

  logic          push_acc;
  logic          pop_acc;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          rd_valid_reg;
  logic          ovf_err_reg;
  logic          udf_err_reg;

  // No bypass: a pop into an empty FIFO is rejected even if a push arrives with it.
  // Reset gates both accepts so the storage is never touched while rst is held.
  assign pop_acc  = pop && !empty && !flush && !rst;
  assign push_acc = push && !flush && !rst && (!full || pop_acc);

  fifo_ptr_cnt #(.AW(AW)) u_ptr_cnt (
    .memclk   (memclk),
    .rst      (rst),
    .flush    (flush),
    .push_acc (push_acc),
    .pop_acc  (pop_acc),
    .wr_ptr   (wr_ptr),
    .rd_ptr   (rd_ptr),
    .count    (count)
  );

  assign mem_wren   = push_acc;
  assign mem_wrptr  = wr_ptr;
  assign mem_wrdata = push_data;
  assign mem_rden   = pop_acc;
  assign mem_rdptr  = rd_ptr;

  assign full         = (count == FULL_CNT);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AFULL_CNT);
  assign almost_empty = (count <= AEMPTY_CNT);

  // Error set takes priority over a same-cycle clear.
  always_ff @(posedge memclk) begin
    if (rst) begin
      rd_valid_reg <= 1'b0;
      ovf_err_reg  <= 1'b0;
      udf_err_reg  <= 1'b0;
    end else begin
      rd_valid_reg <= pop_acc;
      ovf_err_reg  <= (ovf_err_reg && !clr_err) || (push && !push_acc && !flush);
      udf_err_reg  <= (udf_err_reg && !clr_err) || (pop && !pop_acc && !flush);
    end
  end

  assign rd_valid = rd_valid_reg;
  assign ovf_err  = ovf_err_reg;
  assign udf_err  = udf_err_reg;

endmodule : buffer_fifo_ctrl
